tlm_batch_sched: RTL and testbench
==================================

Name: tlm_batch_sched

Overview:
- Round-robin batch scheduler that shares one operand/result datapath (the A/B → res bfm) between NREQ requesters.
- Grants the datapath to one requester per batch and streams that requester's operand pairs into it.
- Tracks in-flight items through a fixed-latency pipeline and returns each result tagged with the owner id.
- Sits between the DPI-fed payload producers and the bfm instance in the TLM testbench top.

Parameters:
NREQ, 2, number of requesters (2..8)
NUM, 100, maximum items per batch; a batch closes at NUM items even without last
ITEM_WIDTH, 8, operand and result width
DP_LATENCY, 1, cycles from dp_valid_o to the matching dp_res_i (1..4)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
req_valid_i  in  NREQ  per-requester item valid
req_ready_o  out  NREQ  per-requester item accept; one-hot or zero
req_a_i  in  NREQ*ITEM_WIDTH  packed operand A, slice r belongs to requester r
req_b_i  in  NREQ*ITEM_WIDTH  packed operand B
req_last_i  in  NREQ  item is the final one of its batch
dp_a_o  out  ITEM_WIDTH  datapath operand A (to bfm A_s)
dp_b_o  out  ITEM_WIDTH  datapath operand B (to bfm B_s)
dp_valid_o  out  1  operands on dp_a_o/dp_b_o are a new item this cycle
dp_res_i  in  ITEM_WIDTH  datapath result (from bfm res_o)
rsp_valid_o  out  1  result valid; no backpressure
rsp_data_o  out  ITEM_WIDTH  result
rsp_id_o  out  max(1,$clog2(NREQ))  owning requester
rsp_last_o  out  1  last result of the batch
busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; rr pointer 0; state IDLE; item count 0; in-flight pipeline cleared.
- Reset mid-batch drops in-flight results; no rsp_valid_o in the cycle after reset.
- States: IDLE, XMIT, DRAIN.
- IDLE: if any req_valid_i, choose grant = first set bit at or above the rr pointer (wrapping), latch it, go to XMIT. Arbitration costs one cycle; req_ready_o = 0 in IDLE.
- XMIT: req_ready_o[grant] = 1; all others 0.
  - Transfer = valid & ready. On a transfer, the registered outputs dp_a_o/dp_b_o/dp_valid_o update next cycle, and count increments.
  - Without a transfer, dp_valid_o = 0 and dp_a_o/dp_b_o hold their last values.
  - Requests from other requesters are ignored until the batch closes.
- Batch close: a transfer with req_last_i[grant] = 1, or the NUM-th transfer. Then go to DRAIN, deassert ready, and reset count to 0.
- DRAIN: wait exactly DP_LATENCY+1 cycles so every issued item retires, then go to IDLE. The rr pointer becomes (grant+1) mod NREQ.
- Retire pipeline: a DP_LATENCY-deep shift register of {valid, id, last}, loaded alongside dp_valid_o.
  - rsp_valid_o/rsp_data_o/rsp_id_o/rsp_last_o are registered one cycle after dp_res_i is sampled.
  - Total item latency is 1 + DP_LATENCY + 1 cycles from transfer to rsp.
- rsp_last_o marks the retiring item that closed its batch.
- Count width: $clog2(NUM+1). A zero-length batch is not possible; a batch carries at least one item.

Optional Feature:
- Macro: TLM_BATCH_SCHED_STATS_EN.
- When defined, adds these outputs, all cleared by reset_i and saturating at all-ones:
  - stat_batches_o, NREQ*16: batches completed per requester, incremented on DRAIN exit.
  - stat_items_o, NREQ*32: items transferred per requester.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package tlm_sched_pkg holds:
  - the state enum (IDLE/XMIT/DRAIN);
  - the function rr_pick(req, ptr, nreq) returning the grant index;
  - the id width localparam helper.
- One sub-module, tlm_sched_retire_pipe: parameterised DP_LATENCY shift register carrying {valid, id, last} and aligning them with dp_res_i.

Test Plan:
- Requester 0 sends 3 items (1,2),(3,4),(5,6 last); bfm res = A+B, DP_LATENCY = 1 → rsp 3, 7, 11 with id 0, rsp_last on 11, each 3 cycles after its transfer.
- Both requesters valid from reset → grant 0 first; after its batch closes, grant 1; on the next contention grant 0 again (round-robin).
- Requester 1 streams 100 items and never asserts last → batch closes at the 100th item, which carries rsp_last; a pending requester 0 is granted after DRAIN.
- Requester 0 drops valid for 2 cycles mid-batch → dp_valid_o low for 2 cycles, dp_a_o/dp_b_o hold, no spurious rsp, ready remains on requester 0.
- reset_i asserted in the cycle after the 2nd transfer of a 5-item batch → no rsp for the dropped items; outputs 0; next grant is requester 0.
- With TLM_BATCH_SCHED_STATS_EN: two batches of 4 from requester 1 → stat_batches_o[1] = 2, stat_items_o[1] = 8, requester 0 counters 0.

Source files
------------

// File: rtl/tlm_sched_pkg.sv
// Shared types and helpers for the batch scheduler: FSM states, round-robin pick, id width.
package tlm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XMIT  = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam int MAX_REQ = 8;

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // First set bit of req at or above ptr, wrapping within nreq requesters.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (i < nreq && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tlm_sched_retire_pipe.sv
// Carries {valid, id, last} of issued items DEPTH cycles so they line up with the datapath result.
module tlm_sched_retire_pipe #(
    parameter int DEPTH = 1,
    parameter int IDW   = 1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           in_valid,
    input  logic [IDW-1:0] in_id,
    input  logic           in_last,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic           out_last
);

    logic           vld_q  [DEPTH];
    logic [IDW-1:0] id_q   [DEPTH];
    logic           last_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k]  <= 1'b0;
                id_q[k]   <= '0;
                last_q[k] <= 1'b0;
            end
        end else begin
            vld_q[0]  <= in_valid;
            id_q[0]   <= in_id;
            last_q[0] <= in_last;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k]  <= vld_q[k-1];
                id_q[k]   <= id_q[k-1];
                last_q[k] <= last_q[k-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/tlm_batch_sched.sv
// Round-robin batch scheduler sharing one A/B->res datapath; item latency 1+DP_LATENCY+1, no rsp backpressure.
// Optional per-requester statistics counters under TLM_BATCH_SCHED_STATS_EN.
module tlm_batch_sched
    import tlm_sched_pkg::*;
#(
    parameter int  NREQ       = 2,
    parameter int  NUM        = 100,
    parameter int  ITEM_WIDTH = 8,
    parameter int  DP_LATENCY = 1,
    localparam int IDW        = id_width(NREQ)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*ITEM_WIDTH-1:0] req_a_i,
    input  logic [NREQ*ITEM_WIDTH-1:0] req_b_i,
    input  logic [NREQ-1:0]            req_last_i,
    output logic [ITEM_WIDTH-1:0]      dp_a_o,
    output logic [ITEM_WIDTH-1:0]      dp_b_o,
    output logic                       dp_valid_o,
    input  logic [ITEM_WIDTH-1:0]      dp_res_i,
    output logic                       rsp_valid_o,
    output logic [ITEM_WIDTH-1:0]      rsp_data_o,
    output logic [IDW-1:0]             rsp_id_o,
    output logic                       rsp_last_o,
    output logic                       busy_o
`ifdef TLM_BATCH_SCHED_STATS_EN
   ,output logic [NREQ*16-1:0]         stat_batches_o,
    output logic [NREQ*32-1:0]         stat_items_o
`endif
);

    localparam int CW = $clog2(NUM + 1);

    sched_state_e   state_q, state_d;
    logic [IDW-1:0] grant_q, rr_q, pick, dp_id_q, ret_id;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     drain_q;
    logic           xfer, close_batch, drain_done, dp_last_q, ret_valid, ret_last;

    assign pick        = IDW'(rr_pick(8'(req_valid_i), 3'(rr_q), NREQ));
    assign xfer        = (state_q == XMIT) && req_valid_i[grant_q];
    assign close_batch = xfer && (req_last_i[grant_q] || cnt_q == CW'(NUM - 1));
    assign drain_done  = (state_q == DRAIN) && (drain_q == 3'(DP_LATENCY));
    assign busy_o      = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        unique case (state_q)
            IDLE:  if (|req_valid_i) state_d = XMIT;
            XMIT: begin
                req_ready_o[grant_q] = 1'b1;
                if (close_batch) state_d = DRAIN;
            end
            DRAIN: if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grant_q     <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            dp_a_o      <= '0;
            dp_b_o      <= '0;
            dp_valid_o  <= 1'b0;
            dp_id_q     <= '0;
            dp_last_q   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rsp_last_o  <= 1'b0;
        end else begin
            if (state_q == IDLE && |req_valid_i) grant_q <= pick;
            if (close_batch)  cnt_q <= '0;
            else if (xfer)    cnt_q <= cnt_q + 1'b1;
            // drain_q counts DRAIN cycles so every issued item has retired before re-arbitration
            drain_q <= (state_q == DRAIN && !drain_done) ? drain_q + 3'd1 : 3'd0;
            if (drain_done) rr_q <= IDW'((int'(grant_q) + 1) % NREQ);
            dp_valid_o <= xfer;
            dp_last_q  <= close_batch;
            if (xfer) begin
                dp_a_o  <= req_a_i[grant_q*ITEM_WIDTH +: ITEM_WIDTH];
                dp_b_o  <= req_b_i[grant_q*ITEM_WIDTH +: ITEM_WIDTH];
                dp_id_q <= grant_q;
            end
            rsp_valid_o <= ret_valid;
            rsp_last_o  <= ret_valid && ret_last;
            if (ret_valid) begin
                rsp_data_o <= dp_res_i;
                rsp_id_o   <= ret_id;
            end
        end
    end

    tlm_sched_retire_pipe #(
        .DEPTH (DP_LATENCY),
        .IDW   (IDW)
    ) u_retire (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .in_valid  (dp_valid_o),
        .in_id     (dp_id_q),
        .in_last   (dp_last_q),
        .out_valid (ret_valid),
        .out_id    (ret_id),
        .out_last  (ret_last)
    );

`ifdef TLM_BATCH_SCHED_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_batches_o <= '0;
            stat_items_o   <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (drain_done && grant_q == IDW'(r) && stat_batches_o[r*16 +: 16] != 16'hFFFF)
                    stat_batches_o[r*16 +: 16] <= stat_batches_o[r*16 +: 16] + 16'd1;
                if (xfer && grant_q == IDW'(r) && stat_items_o[r*32 +: 32] != 32'hFFFF_FFFF)
                    stat_items_o[r*32 +: 32] <= stat_items_o[r*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tlm_batch_sched.sv
// Randomized bench for tlm_batch_sched against a cycle-level scoreboard of grants, datapath issue and responses.
module tb_tlm_batch_sched;

    localparam int NREQ = 2;
    localparam int NUM  = 100;
    localparam int W    = 8;
    localparam int L    = 1;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [NREQ-1:0]     req_valid_i, req_ready_o, req_last_i;
    logic [NREQ*W-1:0]   req_a_i, req_b_i;
    logic [W-1:0]        dp_a_o, dp_b_o, dp_res_i, rsp_data_o;
    logic                dp_valid_o, rsp_valid_o, rsp_last_o, busy_o;
    logic [0:0]          rsp_id_o;
`ifdef TLM_BATCH_SCHED_STATS_EN
    logic [NREQ*16-1:0]  stat_batches_o;
    logic [NREQ*32-1:0]  stat_items_o;
`endif

    always #5 clk_i = ~clk_i;

    tlm_batch_sched #(.NREQ(NREQ), .NUM(NUM), .ITEM_WIDTH(W), .DP_LATENCY(L)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_last_i  (req_last_i),
        .dp_a_o      (dp_a_o),
        .dp_b_o      (dp_b_o),
        .dp_valid_o  (dp_valid_o),
        .dp_res_i    (dp_res_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_last_o  (rsp_last_o),
        .busy_o      (busy_o)
`ifdef TLM_BATCH_SCHED_STATS_EN
       ,.stat_batches_o (stat_batches_o),
        .stat_items_o   (stat_items_o)
`endif
    );

    // bfm stand-in: res = A + B, one cycle after the operands
    always @(posedge clk_i) dp_res_i <= dp_a_o + dp_b_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int due;
        int data;
        int id;
        bit last;
    } exp_t;
    exp_t q[$];

    bit m_active;
    int m_grant, m_ptr, m_cnt, m_idle_at;
    bit e_dpv, nx_dpv;
    int e_a, e_b, nx_a, nx_b;
    int m_bat[NREQ], m_itm[NREQ];

    int left[NREQ], sent[NREQ];
    bit uselast[NREQ];
    int gap_pct;
    bit seqd, rst_now;

    function automatic int rr_model(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return 0;
    endfunction

    function automatic bit quiet();
        bit any = 0;
        for (int r = 0; r < NREQ; r++) if (left[r] != 0) any = 1;
        return !any && !m_active && cyc >= m_idle_at && q.size() == 0;
    endfunction

    task automatic step();
        logic [NREQ-1:0] v;
        int a, b, g;
        bit lst;
        @(negedge clk_i);
        cyc++;
        e_dpv = nx_dpv; e_a = nx_a; e_b = nx_b;
        check_eq("ready", req_ready_o, m_active ? (1 << m_grant) : 0);
        check_eq("busy", busy_o, m_active || cyc < m_idle_at);
        check_eq("dp_valid", dp_valid_o, e_dpv);
        check_eq("dp_a", dp_a_o, e_a);
        check_eq("dp_b", dp_b_o, e_b);
        if (q.size() > 0 && q[0].due == cyc) begin
            check_eq("rsp_valid", rsp_valid_o, 1);
            check_eq("rsp_data", rsp_data_o, q[0].data);
            check_eq("rsp_id", rsp_id_o, q[0].id);
            check_eq("rsp_last", rsp_last_o, q[0].last);
            void'(q.pop_front());
        end else begin
            check_eq("rsp_valid", rsp_valid_o, 0);
        end

        for (int r = 0; r < NREQ; r++) begin
            v[r] = !rst_now && left[r] > 0 && ($urandom_range(99) >= gap_pct);
            a = seqd ? 2*sent[r] + 1 : $urandom_range(255);
            b = seqd ? 2*sent[r] + 2 : $urandom_range(255);
            req_a_i[r*W +: W] = a[W-1:0];
            req_b_i[r*W +: W] = b[W-1:0];
            req_last_i[r] = uselast[r] && left[r] == 1;
        end
        req_valid_i = v;
        reset_i = rst_now;

        nx_dpv = 0; nx_a = e_a; nx_b = e_b;
        if (m_active && v[m_grant]) begin
            g = m_grant;
            nx_dpv = 1;
            nx_a = req_a_i[g*W +: W];
            nx_b = req_b_i[g*W +: W];
            m_cnt++;
            lst = req_last_i[g] || m_cnt == NUM;
            q.push_back('{cyc + L + 2, (nx_a + nx_b) % 256, g, lst});
            left[g]--; sent[g]++; m_itm[g]++;
            if (lst) begin
                m_active = 0; m_cnt = 0;
                m_ptr = (g + 1) % NREQ;
                m_idle_at = cyc + L + 2;
                m_bat[g]++;
            end
        end else if (!m_active && cyc >= m_idle_at && |v) begin
            m_grant = rr_model(v, m_ptr);
            m_active = 1;
        end
        if (rst_now) begin
            rst_now = 0;
            m_active = 0; m_cnt = 0; m_ptr = 0; m_idle_at = cyc + 1;
            q.delete();
            nx_dpv = 0; nx_a = 0; nx_b = 0;
            for (int r = 0; r < NREQ; r++) begin m_bat[r] = 0; m_itm[r] = 0; end
        end
    endtask

    task automatic run_idle(input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (k < budget && !quiet());
        check_eq("phase_done", quiet(), 1);
    endtask

    task automatic do_reset();
        for (int r = 0; r < NREQ; r++) left[r] = 0;
        rst_now = 1;
        step();
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_i = 1; req_valid_i = '0; req_last_i = '0; req_a_i = '0; req_b_i = '0;
        for (int r = 0; r < NREQ; r++) begin
            left[r] = 0; sent[r] = 0; uselast[r] = 1; m_bat[r] = 0; m_itm[r] = 0;
        end
        gap_pct = 0; seqd = 0; rst_now = 0;
        m_active = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; m_idle_at = 0;
        nx_dpv = 0; nx_a = 0; nx_b = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_ready", req_ready_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_dp_valid", dp_valid_o, 0);
        check_eq("rst_rsp_valid", rsp_valid_o, 0);
        check_eq("rst_rsp_data", rsp_data_o, 0);
        check_eq("rst_rsp_last", rsp_last_o, 0);
        reset_i = 0;

        // three sequential items from requester 0: (1,2),(3,4),(5,6 last)
        seqd = 1; left[0] = 3;
        run_idle(100);
        seqd = 0;

        // contention rounds: round-robin alternation
        for (int i = 0; i < 4; i++) begin
            left[0] = 3; left[1] = 3;
            run_idle(200);
        end

        // requester 1 never asserts last: batch closes on the NUM-th item
        uselast[1] = 0; left[1] = NUM;
        k = 0;
        while (!m_active && k < 20) begin step(); k++; end
        check_eq("r1_granted", m_active, 1);
        left[0] = 3;
        run_idle(NUM + 100);
        uselast[1] = 1;

        // random batch sizes with gaps in valid
        gap_pct = 30;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < NREQ; r++) left[r] = $urandom_range(6, 1);
            run_idle(400);
        end
        gap_pct = 0;

        // reset in the cycle after the 2nd transfer of a 5-item batch
        run_idle(50);
        left[0] = 5;
        k = 0;
        while (!(m_active && m_cnt == 2) && k < 20) begin step(); k++; end
        check_eq("two_xfers_seen", m_cnt, 2);
        do_reset();
        left[0] = 1; left[1] = 1;
        k = 0;
        while (req_ready_o == 0 && k < 10) begin step(); k++; end
        check_eq("post_rst_grant", req_ready_o, 1);
        run_idle(100);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            left[1] = 4;
            run_idle(100);
        end
`ifdef TLM_BATCH_SCHED_STATS_EN
        for (int r = 0; r < NREQ; r++) begin
            check_eq("stat_batches", stat_batches_o[r*16 +: 16], m_bat[r]);
            check_eq("stat_items", stat_items_o[r*32 +: 32], m_itm[r]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
